// File: rtl/input_accessory_pkg.sv
// Shared definitions for the PL19/PL20 accessory channels: state encoding and
// default character geometry.
package input_accessory_pkg;

  localparam int unsigned ACC_CODE_W = 5;
  localparam int unsigned ACC_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    ARMED_WAIT
  } acc_in_state_t;

endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module acc_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/input_accessory.sv
// PL19 accessory input responder: host-loaded character FIFO serialised MSB
// first, one bit per shift command, under computer start/stop control.
module input_accessory
  import input_accessory_pkg::*;
#(
  parameter int unsigned CODE_W = ACC_CODE_W,
  parameter int unsigned DEPTH  = ACC_DEPTH
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              PL19_START_INPUT,
  input  logic              PL19_STOP_INPUT,
  input  logic              PL19_SHIFT_CMD_M20,
  output logic              PL19_INPUT,
  input  logic [CODE_W-1:0] char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              reading,
  output logic              underrun
);

  localparam int unsigned CNT_W = $clog2(CODE_W + 1);

  acc_in_state_t        state_q, state_d;
  logic [CODE_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 underrun_q, underrun_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [CODE_W-1:0]    fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign char_ready = ~fifo_full;
  assign fifo_push  = char_valid & ~fifo_full;

  acc_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (char_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assert property (@(posedge CLOCK) disable iff (rst) fifo_empty == (fifo_count == '0));

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    if (PL19_STOP_INPUT) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PL19_START_INPUT) begin
            if (!fifo_empty) begin
              state_d    = ARMED;
              underrun_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        ARMED: begin
          if (PL19_SHIFT_CMD_M20) underrun_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sr_d     = fifo_dout;
            cnt_d    = CNT_W'(CODE_W);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (PL19_SHIFT_CMD_M20) begin
            // Last bit consumed: chain straight into the next code so
            // consecutive characters stream with no gap cycle.
            if (cnt_q == CNT_W'(1)) begin
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                sr_d     = fifo_dout;
                cnt_d    = CNT_W'(CODE_W);
              end else begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = ARMED_WAIT;
              end
            end else begin
              sr_d  = {sr_q[CODE_W-2:0], 1'b0};
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ARMED_WAIT: begin
          if (PL19_SHIFT_CMD_M20) underrun_d = 1'b1;
          if (fifo_push) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign PL19_INPUT = (state_q == SHIFT) & sr_q[CODE_W-1];
  assign reading    = (state_q == ARMED) | (state_q == SHIFT);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_input_accessory.sv
// Self-checking bench for input_accessory: directed scenarios plus a randomized
// run against a queue-based model of the character/bit stream.
module tb_input_accessory;

  localparam int CODE_W = 5;
  localparam int DEPTH  = 4;

  logic              CLOCK = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              shift = 1'b0;
  logic              pl19_in;
  logic [CODE_W-1:0] char_data = '0;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic              reading;
  logic              underrun;

  int n_checks = 0;
  int n_fail   = 0;

  input_accessory #(.CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
    .CLOCK              (CLOCK),
    .rst                (rst),
    .PL19_START_INPUT   (start),
    .PL19_STOP_INPUT    (stop),
    .PL19_SHIFT_CMD_M20 (shift),
    .PL19_INPUT         (pl19_in),
    .char_data          (char_data),
    .char_valid         (char_valid),
    .char_ready         (char_ready),
    .reading            (reading),
    .underrun           (underrun)
  );

  always #5 CLOCK = ~CLOCK;

  // Model: queue of pending codes plus queue of bits still owed from the
  // character currently being read.
  typedef enum {P_IDLE, P_LOAD, P_STREAM, P_STARVED} phase_t;
  logic [CODE_W-1:0] mq[$];
  bit                bits[$];
  phase_t            ph = P_IDLE;
  bit                m_und = 1'b0;

  task automatic load_char(input logic [CODE_W-1:0] code);
    bits.delete();
    for (int i = CODE_W - 1; i >= 0; i--) bits.push_back(code[i]);
  endtask

  function automatic bit exp_bit();
    return (ph == P_STREAM && bits.size() > 0) ? bits[0] : 1'b0;
  endfunction

  task automatic tick();
    bit nonempty;
    bit push;
    logic [CODE_W-1:0] c;
    @(posedge CLOCK);
    nonempty = mq.size() > 0;
    push     = char_valid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      bits.delete();
      ph    = P_IDLE;
      m_und = 1'b0;
    end else begin
      if (stop) begin
        ph = P_IDLE;
        bits.delete();
      end else begin
        case (ph)
          P_IDLE: if (start) begin
            if (nonempty) begin ph = P_LOAD; m_und = 1'b0; end
            else m_und = 1'b1;
          end
          P_LOAD: begin
            if (shift) m_und = 1'b1;
            if (nonempty) begin c = mq.pop_front(); load_char(c); ph = P_STREAM; end
          end
          P_STREAM: if (shift) begin
            void'(bits.pop_front());
            if (bits.size() == 0) begin
              if (nonempty) begin c = mq.pop_front(); load_char(c); end
              else ph = P_STARVED;
            end
          end
          P_STARVED: begin
            if (shift) m_und = 1'b1;
            if (push) ph = P_LOAD;
          end
          default: ph = P_IDLE;
        endcase
      end
      if (push) mq.push_back(char_data);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; shift = 1'b0; char_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_code(input logic [CODE_W-1:0] code);
    char_valid = 1'b1; char_data = code;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic start_and_arm();
    start = 1'b1; tick(); start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({pl19_in, char_ready, reading, underrun} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", {pl19_in, char_ready, reading, underrun}, 4'b0100);
    end
  endtask

  task automatic test_single_char();
    logic [4:0] got = '0;
    do_reset();
    push_code(5'b10110);
    start_and_arm();
    for (int i = 0; i < 5; i++) begin
      got = {got[3:0], pl19_in};
      shift = 1'b1; tick();
    end
    shift = 1'b0;
    n_checks++;
    if (got !== 5'b10110) begin
      n_fail++; $display("FAIL single_bits: got %b expected %b", got, 5'b10110);
    end
    n_checks++;
    if ({pl19_in, reading, underrun} !== 3'b000) begin
      n_fail++; $display("FAIL single_after: pl19/reading/underrun got %b expected 000", {pl19_in, reading, underrun});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got = '0;
    do_reset();
    push_code(5'b11111);
    push_code(5'b00001);
    start_and_arm();
    for (int i = 0; i < 10; i++) begin
      got = {got[8:0], pl19_in};
      shift = 1'b1; tick();
    end
    shift = 1'b0;
    n_checks++;
    if (got !== 10'b1111100001) begin
      n_fail++; $display("FAIL b2b_bits: got %b expected %b", got, 10'b1111100001);
    end
    n_checks++;
    if (reading !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: reading got %b expected 0", reading);
    end
  endtask

  task automatic test_full_fifo();
    logic [19:0] got = '0;
    do_reset();
    push_code(5'b10011);
    push_code(5'b01100);
    push_code(5'b11010);
    push_code(5'b00101);
    n_checks++;
    if (char_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b expected 0", char_ready);
    end
    push_code(5'b11111);
    start_and_arm();
    n_checks++;
    if (char_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_ready: got %b expected 1", char_ready);
    end
    for (int i = 0; i < 20; i++) begin
      got = {got[18:0], pl19_in};
      shift = 1'b1; tick();
    end
    shift = 1'b0;
    n_checks++;
    if (got !== 20'b10011011001101000101) begin
      n_fail++; $display("FAIL full_stream: got %b expected %b", got, 20'b10011011001101000101);
    end
    n_checks++;
    if (reading !== 1'b0) begin
      n_fail++; $display("FAIL full_dropped: reading got %b expected 0", reading);
    end
  endtask

  task automatic test_stop_mid();
    logic [4:0] got = '0;
    do_reset();
    push_code(5'b10101);
    start_and_arm();
    shift = 1'b1; tick(); tick(); shift = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++;
    if ({reading, pl19_in} !== 2'b00) begin
      n_fail++; $display("FAIL stop_idle: reading/pl19 got %b expected 00", {reading, pl19_in});
    end
    push_code(5'b01111);
    start_and_arm();
    for (int i = 0; i < 5; i++) begin
      got = {got[3:0], pl19_in};
      shift = 1'b1; tick();
    end
    shift = 1'b0;
    n_checks++;
    if (got !== 5'b01111) begin
      n_fail++; $display("FAIL stop_next_char: got %b expected %b", got, 5'b01111);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({underrun, reading} !== 2'b10) begin
      n_fail++; $display("FAIL underrun_set: underrun/reading got %b expected 10", {underrun, reading});
    end
    push_code(5'b00111);
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({underrun, reading} !== 2'b01) begin
      n_fail++; $display("FAIL underrun_clear: underrun/reading got %b expected 01", {underrun, reading});
    end
    tick();
    shift = 1'b1;
    repeat (6) tick();
    shift = 1'b0;
    n_checks++;
    if ({underrun, pl19_in, reading} !== 3'b100) begin
      n_fail++; $display("FAIL underrun_wait_shift: underrun/pl19/reading got %b expected 100", {underrun, pl19_in, reading});
    end
  endtask

  task automatic test_start_stop_and_rst();
    do_reset();
    push_code(5'b11001);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_checks++;
    if ({reading, underrun} !== 2'b00) begin
      n_fail++; $display("FAIL start_stop: reading/underrun got %b expected 00", {reading, underrun});
    end
    push_code(5'b10000);
    start_and_arm();
    shift = 1'b1; tick(); shift = 1'b0;
    rst = 1'b1; start = 1'b1; char_valid = 1'b1; char_data = 5'b11111;
    tick();
    rst = 1'b0; start = 1'b0; char_valid = 1'b0;
    n_checks++;
    if ({pl19_in, char_ready, reading, underrun} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_mid: got %b expected 0100", {pl19_in, char_ready, reading, underrun});
    end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({underrun, reading} !== 2'b10) begin
      n_fail++; $display("FAIL rst_fifo_empty: underrun/reading got %b expected 10", {underrun, reading});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst        = ($urandom_range(0, 249) == 0);
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      shift      = ($urandom_range(0, 1) == 0);
      char_valid = ($urandom_range(0, 2) == 0);
      char_data  = CODE_W'($urandom);
      tick();
      n_checks++;
      if (pl19_in !== exp_bit()) begin
        n_fail++; $display("FAIL rand_pl19 cyc %0d: got %b expected %b", cyc, pl19_in, exp_bit());
      end
      n_checks++;
      if (reading !== (ph == P_LOAD || ph == P_STREAM)) begin
        n_fail++; $display("FAIL rand_reading cyc %0d: got %b expected %b", cyc, reading, (ph == P_LOAD || ph == P_STREAM));
      end
      n_checks++;
      if (underrun !== m_und) begin
        n_fail++; $display("FAIL rand_underrun cyc %0d: got %b expected %b", cyc, underrun, m_und);
      end
      n_checks++;
      if (char_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, char_ready, (mq.size() < DEPTH));
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; shift = 1'b0; char_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_single_char();
    test_back_to_back();
    test_full_fifo();
    test_stop_mid();
    test_underrun();
    test_start_stop_and_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
